// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle add/xor/not/zero ops
// and a one-bit-per-cycle shifter (LSL, LSR, ASR).
module alu_seq #(
   parameter int W  = 8,
   parameter int SW = $clog2(W)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [2:0]    aluop,
   input  logic [1:0]    mode,
   input  logic [W-1:0]  data,
   input  logic [W-1:0]  datb,
   input  logic          sci,
   input  logic          ci,
   output logic [W-1:0]  rslt,
   output logic          co,
   output logic          sco,
   output logic          gt,
   output logic          eq,
   output logic          clear,
   output logic          busy,
   output logic          done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   wreg_q, wreg_d;
   logic [SW-1:0]  cnt_q, cnt_d;
   logic [1:0]     mode_q, mode_d;
   logic [W-1:0]   rslt_d;
   logic           co_d, sco_d, gt_d, eq_d, clear_d, busy_d, done_d;

   logic [W-1:0]   sh_in, sh_out;
   logic [1:0]     sh_mode;
   logic           sh_bit, sh_co, sh_sco;
   logic [W:0]     sum;
   logic [SW-1:0]  n;

   // one-bit shift step; the accept edge shifts the raw operand,
   // later edges shift the working register
   always_comb begin
      sh_in   = (state_q == SHIFT) ? wreg_q : data;
      sh_mode = (state_q == SHIFT) ? mode_q : mode;
      sh_out  = sh_in;
      sh_bit  = 1'b0;
      case (sh_mode)
         2'b00: begin
            sh_out = {sh_in[W-2:0], 1'b0};
            sh_bit = sh_in[W-1];
         end
         2'b10: begin
            sh_out = {1'b0, sh_in[W-1:1]};
            sh_bit = sh_in[0];
         end
         2'b11: begin
            sh_out = {sh_in[W-1], sh_in[W-1:1]};
            sh_bit = sh_in[0];
         end
         default: begin
            sh_out = sh_in;
            sh_bit = 1'b0;
         end
      endcase
      sh_sco = (sh_mode == 2'b00) & sh_bit;
      sh_co  = (sh_mode != 2'b00) & sh_bit;
      sum    = {1'b0, data} + {1'b0, datb}
             + {{W{1'b0}}, sci} + {{W{1'b0}}, ci};
      n      = datb[SW-1:0];
   end

   // next-state and result logic; results only change with done
   always_comb begin
      state_d = state_q;
      wreg_d  = wreg_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      rslt_d  = rslt;
      co_d    = co;
      sco_d   = sco;
      gt_d    = gt;
      eq_d    = eq;
      clear_d = clear;
      busy_d  = busy;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               rslt_d  = '0;
               co_d    = 1'b0;
               sco_d   = 1'b0;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               clear_d = 1'b0;
               done_d  = 1'b1;
               case (aluop)
                  3'b000: begin
                     {co_d, rslt_d} = sum;
                     clear_d = 1'b1;
                     gt_d    = data > datb;
                     eq_d    = data == datb;
                  end
                  3'b001: rslt_d = data ^ datb;
                  3'b101: begin
                     if (mode == 2'b01) begin
                        rslt_d = ~data;
                     end else if (n == '0) begin
                        rslt_d = data;
                     end else if (n == SW'(1)) begin
                        rslt_d = sh_out;
                        co_d   = sh_co;
                        sco_d  = sh_sco;
                     end else begin
                        // multi-cycle: hold visible results
                        rslt_d  = rslt;
                        co_d    = co;
                        sco_d   = sco;
                        gt_d    = gt;
                        eq_d    = eq;
                        clear_d = clear;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        wreg_d  = sh_out;
                        cnt_d   = n - SW'(1);
                        mode_d  = mode;
                        state_d = SHIFT;
                     end
                  end
                  default: rslt_d = '0;
               endcase
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            wreg_d = sh_out;
            cnt_d  = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
               rslt_d  = sh_out;
               co_d    = sh_co;
               sco_d   = sh_sco;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               clear_d = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wreg_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         rslt    <= '0;
         co      <= 1'b0;
         sco     <= 1'b0;
         gt      <= 1'b0;
         eq      <= 1'b0;
         clear   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         wreg_q  <= wreg_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         rslt    <= rslt_d;
         co      <= co_d;
         sco     <= sco_d;
         gt      <= gt_d;
         eq      <= eq_d;
         clear   <= clear_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at W=8 and W=16.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset, start, start16;
   logic [2:0]  aluop;
   logic [1:0]  mode;
   logic [7:0]  a, b;
   logic [15:0] a16, b16;
   logic        sci, ci;
   logic [7:0]  rslt;
   logic [15:0] rslt16;
   logic        co, sco, gt, eq, clear, busy, done;
   logic        co16, sco16, gt16, eq16, clear16, busy16, done16;
   int          ntests = 0;
   int          nfail = 0;
   int          cyc;
   int          ndone;

   always #5 clk = ~clk;

   alu_seq #(.W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .aluop(aluop),
      .mode(mode), .data(a), .datb(b), .sci(sci), .ci(ci),
      .rslt(rslt), .co(co), .sco(sco), .gt(gt), .eq(eq),
      .clear(clear), .busy(busy), .done(done)
   );

   alu_seq #(.W(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .aluop(aluop),
      .mode(mode), .data(a16), .datb(b16), .sci(sci), .ci(ci),
      .rslt(rslt16), .co(co16), .sco(sco16), .gt(gt16), .eq(eq16),
      .clear(clear16), .busy(busy16), .done(done16)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one-edge start pulse; operands scrambled right after accept
   task automatic issue(input logic [2:0] op, input logic [1:0] md,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic isci, input logic ici);
      aluop = op; mode = md; a = ia; b = ib; sci = isci; ci = ici;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = ~ia; b = ~ib; aluop = 3'b001; mode = 2'b01;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("done_timeout", {31'b0, done}, 32'h1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start16 = 1'b0;
      aluop = '0; mode = '0; a = '0; b = '0;
      a16 = '0; b16 = '0; sci = 1'b0; ci = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_rslt", {24'b0, rslt}, 32'h0);
      check("rst_flags", {25'b0, co, sco, gt, eq, clear, busy, done}, 32'h0);
      check("rst_rslt16", {16'b0, rslt16}, 32'h0);

      issue(3'b000, 2'b00, 8'hF0, 8'h20, 1'b1, 1'b1);
      check("add_rslt", {24'b0, rslt}, 32'h12);
      check("add_flags", {26'b0, done, co, gt, eq, clear, sco}, 32'b111010);

      issue(3'b000, 2'b00, 8'h55, 8'h55, 1'b0, 1'b0);
      check("add_eq_rslt", {24'b0, rslt}, 32'hAA);
      check("add_eq_flags", {28'b0, co, gt, eq, clear}, 32'b0011);

      issue(3'b001, 2'b00, 8'h3C, 8'h0F, 1'b1, 1'b1);
      check("xor_rslt", {24'b0, rslt}, 32'h33);
      check("xor_flags", {26'b0, done, co, gt, eq, clear, sco}, 32'b100000);

      issue(3'b010, 2'b00, 8'hFF, 8'h01, 1'b0, 1'b0);
      check("zero_rslt", {24'b0, rslt}, 32'h0);
      issue(3'b001, 2'b00, 8'h01, 8'h00, 1'b0, 1'b0);
      issue(3'b111, 2'b00, 8'hFF, 8'h01, 1'b0, 1'b0);
      check("undef_rslt", {24'b0, rslt}, 32'h0);

      issue(3'b101, 2'b01, 8'h5A, 8'h03, 1'b0, 1'b0);
      check("not_rslt", {24'b0, rslt}, 32'hA5);
      check("not_done", {30'b0, done, busy}, 32'b10);

      issue(3'b101, 2'b11, 8'h81, 8'h03, 1'b0, 1'b0);
      check("asr_c1", {22'b0, busy, done, rslt}, {22'b0, 2'b10, 8'hA5});
      tick();
      check("asr_c2", {22'b0, busy, done, rslt}, {22'b0, 2'b10, 8'hA5});
      tick();
      check("asr_c3", {22'b0, busy, done, rslt}, {22'b0, 2'b01, 8'hF0});
      check("asr_co", {30'b0, co, sco}, 32'b00);

      issue(3'b101, 2'b00, 8'hC0, 8'h02, 1'b0, 1'b0);
      check("lsl_c1", {30'b0, busy, done}, 32'b10);
      tick();
      check("lsl_rslt", {24'b0, rslt}, 32'h00);
      check("lsl_flags", {29'b0, done, co, sco}, 32'b101);

      issue(3'b101, 2'b10, 8'h01, 8'h01, 1'b0, 1'b0);
      check("lsr1_rslt", {24'b0, rslt}, 32'h00);
      check("lsr1_flags", {28'b0, busy, done, co, sco}, 32'b0110);

      issue(3'b101, 2'b00, 8'h77, 8'h08, 1'b0, 1'b0);
      check("n0_rslt", {24'b0, rslt}, 32'h77);
      check("n0_flags", {28'b0, busy, done, co, sco}, 32'b0100);
      tick();
      check("hold", {23'b0, done, rslt}, {23'b0, 1'b0, 8'h77});

      issue(3'b101, 2'b11, 8'h80, 8'h07, 1'b0, 1'b0);
      aluop = 3'b001; a = 8'h0F; b = 8'hF0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      check("asr7_lat", cyc + 2, 7);
      check("asr7_rslt", {24'b0, rslt}, 32'hFF);
      check("asr7_co", {31'b0, co}, 32'h0);
      issue(3'b001, 2'b00, 8'hAA, 8'hFF, 1'b0, 1'b0);
      check("b2b_rslt", {24'b0, rslt}, 32'h55);
      check("b2b_done", {31'b0, done}, 32'h1);
      tick();
      check("b2b_single", {30'b0, busy, done}, 32'b00);

      issue(3'b101, 2'b10, 8'hF0, 8'h05, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort", {22'b0, busy, done, rslt}, 32'h0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         ndone += int'(done);
      end
      check("abort_nodone", ndone, 0);

      aluop = 3'b000; mode = 2'b00; sci = 1'b0; ci = 1'b0;
      a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("add16_rslt", {16'b0, rslt16}, 32'h0);
      check("add16_flags", {29'b0, done16, co16, gt16}, 32'b111);

      aluop = 3'b101; mode = 2'b10;
      a16 = 16'h8000; b16 = 16'd15; start16 = 1'b1;
      tick();
      start16 = 1'b0; a16 = 16'h1234;
      cyc = 0;
      while (!done16 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("lsr16_lat", cyc + 1, 15);
      check("lsr16_rslt", {16'b0, rslt16}, 32'h0001);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
